// File: rtl/arm_pkg.sv
// Shared definitions for the ARM fetch front end.
//   fetch_state_t : fetch FSM state encoding
//   INSTR_W       : instruction width
//   PC_INC        : sequential PC step
//   PC_R15_OFS    : offset of the R15 read value from the instruction address
//   word_align()  : forces an address onto a 32-bit word boundary
package arm_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    ERROR = 2'd2
  } fetch_state_t;

  localparam int unsigned    INSTR_W    = 32;
  localparam logic [31:0]    PC_INC     = 32'd4;
  localparam logic [31:0]    PC_R15_OFS = 32'd8;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Memory-response watchdog for the fetch stage.
// Counts cycles while en=1, returns to zero on clr (clr wins over en).
// expired is high while the count sits at TIMEOUT-1, i.e. during the
// TIMEOUT-th consecutive enabled cycle.
//   clk, reset : clock and synchronous active-high reset
//   clr        : return count to zero
//   en         : advance count by one
//   expired    : count has reached TIMEOUT-1
module fetch_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding the ARM controller/datapath.
// Owns the PC, issues one word read per instruction to a variable-latency
// memory, and holds the returned instruction (with PC and PC+8) until the
// consumer accepts it. The consumer's PCSrc/branch_target choose the next PC
// on acceptance; flush redirects from any state; a memory that never answers
// parks the stage in a sticky error state.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   FETCH | request outstanding at pc, waiting for imem_ready
//   HOLD  | instruction held on Instr/PC/PCPlus8, waiting for instr_ready
//   ERROR | memory timed out; leave only via flush or reset
//
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   imem_req/imem_addr        : memory read request and word address
//   imem_rdata/imem_ready     : memory response data and strobe
//   instr_valid/instr_ready   : handshake with the consumer
//   Instr, PC, PCPlus8        : held instruction, its address, address+8
//   PCSrc, branch_target      : next-PC select, sampled on acceptance
//   flush, flush_pc           : immediate redirect
//   fetch_err                 : sticky memory-timeout flag
module instr_fetch
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] Instr,
  output logic [31:0]        PC,
  output logic [31:0]        PCPlus8,
  input  logic               PCSrc,
  input  logic [31:0]        branch_target,
  input  logic               flush,
  input  logic [31:0]        flush_pc,
  output logic               fetch_err
);

  fetch_state_t        state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                imem_req_q, imem_req_d;
  logic                instr_valid_q, instr_valid_d;
  logic                fetch_err_q, fetch_err_d;
  logic                timer_clr, timer_en, timer_expired;

  fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;

    if (flush) begin
      pc_d      = word_align(flush_pc);
      state_d   = FETCH;
      timer_clr = 1'b1;
    end else begin
      unique case (state_q)
        FETCH: begin
          // The cycle right after reset is FETCH with the request not yet
          // on the bus; nothing may be accepted or counted until it is.
          if (imem_req_q) begin
            if (imem_ready) begin
              instr_d   = imem_rdata;
              state_d   = HOLD;
              timer_clr = 1'b1;
            end else if (timer_expired) begin
              state_d   = ERROR;
              timer_clr = 1'b1;
            end else begin
              timer_en  = 1'b1;
            end
          end
        end
        HOLD: begin
          timer_clr = 1'b1;
          if (instr_ready) begin
            pc_d    = PCSrc ? word_align(branch_target) : pc_q + PC_INC;
            state_d = FETCH;
          end
        end
        ERROR: begin
          timer_clr = 1'b1;
        end
        default: begin
          state_d   = FETCH;
          timer_clr = 1'b1;
        end
      endcase
    end

    imem_req_d    = (state_d == FETCH);
    instr_valid_d = (state_d == HOLD);
    fetch_err_d   = (state_d == ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= word_align(RESET_PC);
      instr_q       <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign Instr       = instr_q;
  assign PC          = pc_q;
  assign PCPlus8     = pc_q + PC_R15_OFS;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus8;
  logic        PCSrc;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .Instr         (Instr),
    .PC            (PC),
    .PCPlus8       (PCPlus8),
    .PCSrc         (PCSrc),
    .branch_target (branch_target),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: "waiting on memory", "holding an
  // instruction", "errored", or idle just after reset.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_req, m_valid, m_err;
  int          m_wait;
  bit          model_live = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = RESET_PC; m_instr = 0; m_req = 0; m_valid = 0; m_err = 0; m_wait = 0;
      model_live = 1;
    end else if (flush) begin
      m_pc = {flush_pc[31:2], 2'b00}; m_req = 1; m_valid = 0; m_err = 0; m_wait = 0;
    end else if (m_req) begin
      if (imem_ready) begin
        m_instr = imem_rdata; m_req = 0; m_valid = 1; m_wait = 0;
      end else begin
        m_wait = m_wait + 1;
        if (m_wait == TIMEOUT) begin
          m_req = 0; m_err = 1; m_wait = 0;
        end
      end
    end else if (m_valid) begin
      if (instr_ready) begin
        m_pc    = PCSrc ? {branch_target[31:2], 2'b00} : m_pc + 32'd4;
        m_valid = 0;
        m_req   = 1;
      end
    end else if (!m_err) begin
      m_req = 1;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      cmp("model imem_req",    {31'd0, imem_req},    {31'd0, m_req});
      cmp("model imem_addr",   imem_addr,            m_pc);
      cmp("model instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      cmp("model Instr",       Instr,                m_instr);
      cmp("model PC",          PC,                   m_pc);
      cmp("model PCPlus8",     PCPlus8,              m_pc + 32'd8);
      cmp("model fetch_err",   {31'd0, fetch_err},   {31'd0, m_err});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; imem_rdata = 0; imem_ready = 0; instr_ready = 0;
    PCSrc = 0; branch_target = 0; flush = 0; flush_pc = 0;
    step(); step();
    // reset cycle
    cmp("rst imem_req", {31'd0, imem_req}, 32'd0);
    cmp("rst instr_valid", {31'd0, instr_valid}, 32'd0);
    cmp("rst Instr", Instr, 32'd0);
    cmp("rst fetch_err", {31'd0, fetch_err}, 32'd0);

    reset = 0; step();
    cmp("first req", {31'd0, imem_req}, 32'd1);
    cmp("first addr", imem_addr, 32'h0);

    imem_ready = 1; imem_rdata = 32'hE3A0_1005; step();
    imem_ready = 0; imem_rdata = 0;
    cmp("lat valid", {31'd0, instr_valid}, 32'd1);
    cmp("lat Instr", Instr, 32'hE3A0_1005);
    cmp("lat PC", PC, 32'h0);
    cmp("lat PCPlus8", PCPlus8, 32'h8);
    cmp("lat req low", {31'd0, imem_req}, 32'd0);

    // backpressure, PCSrc must be ignored without instr_ready
    PCSrc = 1; branch_target = 32'h500;
    for (int i = 0; i < 3; i++) begin
      step();
      cmp("bp Instr", Instr, 32'hE3A0_1005);
      cmp("bp PC", PC, 32'h0);
      cmp("bp valid", {31'd0, instr_valid}, 32'd1);
    end
    PCSrc = 0; instr_ready = 1; step();
    instr_ready = 0;
    cmp("seq addr", imem_addr, 32'h4);
    cmp("seq valid drop", {31'd0, instr_valid}, 32'd0);
    cmp("seq req", {31'd0, imem_req}, 32'd1);

    // two wait cycles then response
    step(); step();
    imem_ready = 1; imem_rdata = 32'h1111_1111; step();
    imem_ready = 0;
    cmp("wait Instr", Instr, 32'h1111_1111);
    cmp("wait PC", PC, 32'h4);

    // branch
    PCSrc = 1; branch_target = 32'h0000_0103; instr_ready = 1; step();
    instr_ready = 0; PCSrc = 0;
    cmp("branch addr", imem_addr, 32'h100);

    // wrap
    flush = 1; flush_pc = 32'hFFFF_FFFE; step();
    flush = 0;
    cmp("wrap addr", imem_addr, 32'hFFFF_FFFC);
    cmp("wrap PCPlus8", PCPlus8, 32'h4);
    imem_ready = 1; imem_rdata = 32'h2222_2222; step();
    imem_ready = 0;
    instr_ready = 1; step();
    instr_ready = 0;
    cmp("wrap next addr", imem_addr, 32'h0);

    // flush collides with memory response
    flush = 1; flush_pc = 32'h200; imem_ready = 1; imem_rdata = 32'hDEAD_BEEF; step();
    flush = 0; imem_ready = 0;
    cmp("coll Instr", Instr, 32'h2222_2222);
    cmp("coll addr", imem_addr, 32'h200);
    cmp("coll valid", {31'd0, instr_valid}, 32'd0);
    cmp("coll req", {31'd0, imem_req}, 32'd1);

    // timeout
    step(); step(); step();
    cmp("to not yet", {31'd0, fetch_err}, 32'd0);
    step();
    cmp("to err", {31'd0, fetch_err}, 32'd1);
    cmp("to req", {31'd0, imem_req}, 32'd0);
    step();
    cmp("to sticky", {31'd0, fetch_err}, 32'd1);
    flush = 1; flush_pc = 32'h40; step();
    flush = 0;
    cmp("to clr err", {31'd0, fetch_err}, 32'd0);
    cmp("to flush addr", imem_addr, 32'h40);
    cmp("to flush req", {31'd0, imem_req}, 32'd1);

    // flush during HOLD overrides the consumer
    imem_ready = 1; imem_rdata = 32'h3333_3333; step();
    imem_ready = 0;
    flush = 1; flush_pc = 32'h80; instr_ready = 1; PCSrc = 1; branch_target = 32'h300; step();
    flush = 0; instr_ready = 0; PCSrc = 0;
    cmp("hflush addr", imem_addr, 32'h80);
    cmp("hflush valid", {31'd0, instr_valid}, 32'd0);

    // reset mid-HOLD
    imem_ready = 1; imem_rdata = 32'h4444_4444; step();
    imem_ready = 0;
    cmp("pre-rst valid", {31'd0, instr_valid}, 32'd1);
    reset = 1; step();
    cmp("mrst valid", {31'd0, instr_valid}, 32'd0);
    cmp("mrst Instr", Instr, 32'd0);
    cmp("mrst req", {31'd0, imem_req}, 32'd0);
    cmp("mrst PC", PC, RESET_PC);
    reset = 0; step();
    cmp("mrst req rise", {31'd0, imem_req}, 32'd1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the ARM controller/datapath.
- Owns the PC and issues word reads to a variable-latency instruction memory.
- Holds each fetched instruction stable, with PC and PC+8, until the controller/datapath accepts it.
- On acceptance, applies the consumer's PCSrc/branch target to select the next PC; supports an external flush and a memory-timeout error.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, max cycles in FETCH without imem_ready before error; legal range 2..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- imem_req  output  1  read request to instruction memory
- imem_addr  output  32  word-aligned fetch address (= pc)
- imem_rdata  input  32  instruction data, valid when imem_ready=1
- imem_ready  input  1  memory response strobe
- instr_valid  output  1  Instr/PC/PCPlus8 hold a valid instruction
- instr_ready  input  1  controller/datapath accepts the held instruction this cycle
- Instr  output  32  held instruction; [31:12] feeds the controller
- PC  output  32  address of the held instruction
- PCPlus8  output  32  PC+8 (ARM R15 read value)
- PCSrc  input  1  qualified with instr_ready; 1 = take branch_target
- branch_target  input  32  next PC when PCSrc=1
- flush  input  1  redirect fetch immediately
- flush_pc  input  32  redirect address
- fetch_err  output  1  sticky timeout error

Behaviour:
- Reset (sync, highest priority):
  - pc=RESET_PC, state=FETCH, timer=0.
  - Instr=0, instr_valid=0, imem_req=0 during the reset cycle, fetch_err=0.
  - imem_req rises in the first cycle after reset deasserts.
- States: FETCH, HOLD, ERROR.
- FETCH:
  - imem_req=1; imem_addr=pc, stable until the response.
  - imem_ready=1: Instr<=imem_rdata, timer<=0, next state HOLD; instr_valid=1 from the next cycle.
  - No ready: timer increments; at timer==TIMEOUT-1 without ready → ERROR.
  - Minimum latency: ready in the first request cycle gives instr_valid the following cycle.
- HOLD:
  - imem_req=0, instr_valid=1; Instr, PC and PCPlus8 stay constant while instr_ready=0.
  - instr_ready=1: pc<={branch_target[31:2],2'b00} if PCSrc, else pc+4; next state FETCH; instr_valid=0 next cycle.
  - PCSrc and branch_target are ignored when instr_ready=0.
  - Peak throughput: one instruction per 2 cycles.
- ERROR:
  - imem_req=0, instr_valid=0, fetch_err=1.
  - Exited only by reset or flush.
- flush (priority below reset, above everything else):
  - Any state: pc<={flush_pc[31:2],2'b00}, state=FETCH, timer=0, instr_valid=0 next cycle, fetch_err cleared.
  - A same-cycle imem_ready is discarded; Instr is not updated.
  - A same-cycle instr_ready/PCSrc is ignored; no next-PC update from the consumer.
- Arithmetic:
  - pc+4 and pc+8 are 32-bit modulo; 0xFFFF_FFFC+4 wraps to 0.
  - pc[1:0] is always 00.
- Outputs: all registered except imem_addr=pc, PC=pc and PCPlus8=pc+8, which are combinational from the pc register.
- instr_valid never drops without instr_ready, flush or reset.

Decomposition:
- Shared package arm_pkg:
  - fetch_state_t enum {FETCH, HOLD, ERROR}.
  - Constants INSTR_W=32, PC_INC=4, PC_R15_OFS=8.
- One sub-module: fetch_timer, a TIMEOUT-bounded counter with clear/enable and an expired output.

Test Plan:
- Reset sequencing, RESET_PC=0 → reset cycle: imem_req=0. Next cycle: imem_req=1, imem_addr=0. Memory returns 0xE3A0_1005 with 0 wait cycles → next cycle: instr_valid=1, Instr=0xE3A01005, PC=0, PCPlus8=8.
- Backpressure then sequential accept → instr_ready low 3 cycles: Instr/PC unchanged. Accept with PCSrc=0 → next imem_addr=4. Repeat at pc=0xFFFF_FFFC → next imem_addr=0 (wrap).
- Branch accept → PCSrc=1, branch_target=0x0000_0103 with instr_ready=1 → next imem_addr=0x100. PCSrc=1 with instr_ready=0 → no change.
- Flush collision → flush=1, flush_pc=0x200 in the same cycle as imem_ready with data 0xDEADBEEF → Instr not updated, imem_addr=0x200 next cycle, instr_valid stays 0.
- Timeout, TIMEOUT=4 → no imem_ready for 4 cycles → fetch_err=1, imem_req=0. Then flush to 0x40 → fetch_err=0, imem_addr=0x40, imem_req=1.
- Reset mid-HOLD → reset while instr_valid=1 → next cycle: instr_valid=0, Instr=0, imem_req=0, pc=RESET_PC.
